// File: rtl/sdram_init_wb_ctrl.sv
// SDRAM power-up init sequencer (NOP wait, PRECHARGE ALL, auto-refreshes, LOAD MODE) with a Wishbone ack front end.
// Define PERIODIC_REFRESH_EN to build the periodic auto-refresh scheduler that runs in IDLE.
module sdram_init_wb_ctrl #(
    parameter int          INIT_CYCLES  = 10000,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          INIT_REFRESH = 8,
    parameter int          REF_INT      = 1560,
    parameter logic [12:0] MODE_REG     = 13'h033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        sdram_init_done,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba
);

    localparam int CNT_MAX = (INIT_CYCLES > REF_INT) ? INIT_CYCLES : REF_INT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(INIT_REFRESH + 1);

    // Wait counters are loaded with (t - 2) and exit on zero, giving t-1 NOP cycles.
    localparam logic [CW-1:0] RP_WAIT  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] RFC_WAIT = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] MRD_WAIT = CW'((T_MRD > 1) ? T_MRD - 2 : 0);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef enum logic [3:0] {
        S_RESET, S_PWRUP, S_PRE, S_PRE_WAIT, S_REF, S_REF_WAIT,
        S_LMR, S_LMR_WAIT, S_IDLE, S_AREF, S_AREF_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [12:0]     addr_q, addr_d;
    logic            ack_q, ack_d;
    logic            done_q, done_d;
`ifdef PERIODIC_REFRESH_EN
    logic [CW-1:0]   tmr_q, tmr_d;
    logic            pending_q, pending_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_cnt_d = ref_cnt_q;
        done_d    = done_q;
`ifdef PERIODIC_REFRESH_EN
        tmr_d     = tmr_q;
        pending_d = pending_q;
`endif
        case (state_q)
            S_RESET: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
            S_PWRUP: begin
                if (cnt_q == CW'(INIT_CYCLES - 1)) state_d = S_PRE;
                else                               cnt_d   = cnt_q + CW'(1);
            end
            S_PRE: begin
                cnt_d   = RP_WAIT;
                state_d = (T_RP > 1) ? S_PRE_WAIT : S_REF;
            end
            S_PRE_WAIT: begin
                if (cnt_q == '0) state_d = S_REF;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_REF: begin
                ref_cnt_d = ref_cnt_q + RW'(1);
                cnt_d     = RFC_WAIT;
                if (T_RFC > 1)                            state_d = S_REF_WAIT;
                else if (ref_cnt_d == RW'(INIT_REFRESH))  state_d = S_LMR;
                else                                      state_d = S_REF;
            end
            S_REF_WAIT: begin
                if (cnt_q != '0)                          cnt_d   = cnt_q - CW'(1);
                else if (ref_cnt_q == RW'(INIT_REFRESH))  state_d = S_LMR;
                else                                      state_d = S_REF;
            end
            S_LMR: begin
                cnt_d = MRD_WAIT;
                if (T_MRD > 1) begin
                    state_d = S_LMR_WAIT;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_LMR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_IDLE: begin
`ifdef PERIODIC_REFRESH_EN
                if (tmr_q == CW'(REF_INT - 1)) begin
                    tmr_d     = '0;
                    pending_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
                // A pending refresh is taken ahead of any new strobe, but never in an ack cycle.
                if (pending_q && !ack_q) begin
                    state_d   = S_AREF;
                    pending_d = 1'b0;
                end
`endif
            end
            S_AREF: begin
                cnt_d   = RFC_WAIT;
                state_d = (T_RFC > 1) ? S_AREF_WAIT : S_IDLE;
            end
            S_AREF_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_RESET;
        endcase

        ack_d = (state_d == S_IDLE) && wb_cyc_i && wb_stb_i && !ack_q;

        cmd_d  = CMD_NOP;
        addr_d = '0;
        case (state_d)
            S_PRE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            S_REF, S_AREF: cmd_d = CMD_REF;
            S_LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            default: ;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_INHIBIT;
            addr_q    <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef PERIODIC_REFRESH_EN
            tmr_q     <= '0;
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
`ifdef PERIODIC_REFRESH_EN
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
`endif
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_a         = addr_q;
    assign sdram_ba        = 2'b00;
    assign wb_ack_o        = ack_q;
    assign sdram_init_done = done_q;

endmodule

// File: tb/tb_sdram_init_wb_ctrl.sv
// Scoreboard bench for sdram_init_wb_ctrl: expected commands and acks are queued with their cycle
// numbers (counted from reset release) and compared against the DUT every cycle on the falling edge.
module tb_sdram_init_wb_ctrl;

    localparam int          INIT_CYCLES  = 10000;
    localparam int          T_RP         = 2;
    localparam int          T_RFC        = 7;
    localparam int          T_MRD        = 2;
    localparam int          INIT_REFRESH = 8;
    localparam int          REF_INT      = 1560;
    localparam logic [12:0] MODE_REG     = 13'h033;
    localparam int          NEVER        = 32'h3fff_ffff;

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef struct {
        int          t;
        logic [3:0]  cmd;
        logic [12:0] a;
    } cmd_ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o, sdram_init_done;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;

    cmd_ev_t cmd_sb[$];
    int      ack_sb[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      tcnt     = -1;     // rising edges since reset release; -1 while in reset
    int      done_t   = NEVER;  // cycle at which init_done is expected to rise

    sdram_init_wb_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .T_RP        (T_RP),
        .T_RFC       (T_RFC),
        .T_MRD       (T_MRD),
        .INIT_REFRESH(INIT_REFRESH),
        .REF_INT     (REF_INT),
        .MODE_REG    (MODE_REG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_ack_o       (wb_ack_o),
        .sdram_init_done(sdram_init_done),
        .sdram_cs_n     (sdram_cs_n),
        .sdram_ras_n    (sdram_ras_n),
        .sdram_cas_n    (sdram_cas_n),
        .sdram_we_n     (sdram_we_n),
        .sdram_a        (sdram_a),
        .sdram_ba       (sdram_ba)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt <= rst ? -1 : tcnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, tcnt, got, exp);
    endtask

    task automatic monitor();
        logic [3:0]  exp_cmd;
        logic [12:0] exp_a;
        logic        exp_ack;
        exp_cmd = (tcnt < 0) ? CMD_INHIBIT : CMD_NOP;
        exp_a   = '0;
        if (cmd_sb.size() > 0 && cmd_sb[0].t == tcnt) begin
            exp_cmd = cmd_sb[0].cmd;
            exp_a   = cmd_sb[0].a;
            void'(cmd_sb.pop_front());
        end
        exp_ack = 1'b0;
        if (ack_sb.size() > 0 && ack_sb[0] == tcnt) begin
            exp_ack = 1'b1;
            void'(ack_sb.pop_front());
        end
        check("cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, exp_cmd);
        check("addr", sdram_a, exp_a);
        check("ba", sdram_ba, 2'b00);
        check("init_done", sdram_init_done, tcnt >= done_t);
        check("ack", wb_ack_o, exp_ack);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_until(input int t);
        int guard = 0;
        while (tcnt < t && guard < 30000) begin
            tick();
            guard++;
        end
        check("run_until", tcnt, t);
    endtask

    task automatic push_cmd(input int t, input logic [3:0] cmd, input logic [12:0] a);
        cmd_ev_t ev;
        ev.t   = t;
        ev.cmd = cmd;
        ev.a   = a;
        cmd_sb.push_back(ev);
    endtask

    task automatic push_init();
        int t;
        push_cmd(INIT_CYCLES, CMD_PRE, 13'h0400);
        t = INIT_CYCLES + T_RP;
        for (int i = 0; i < INIT_REFRESH; i++) begin
            push_cmd(t, CMD_REF, 13'h0000);
            t += T_RFC;
        end
        push_cmd(t, CMD_LMR, MODE_REG);
        done_t = t + T_MRD;
    endtask

    // Holds rst for n cycles (each one checked as a reset cycle), then queues a full init sequence.
    task automatic do_reset(input int n);
        cmd_sb.delete();
        ack_sb.delete();
        done_t = NEVER;
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        push_init();
    endtask

    initial begin
        int aref_t;

        // Strobe held from reset: no ack may appear before init completes.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        do_reset(3);
        run_until(5000);

        // Single-cycle reset in the middle of the power-up wait restarts the whole count.
        do_reset(1);
        ack_sb.push_back(done_t);
        ack_sb.push_back(done_t + 2);
        ack_sb.push_back(done_t + 4);
        run_until(done_t + 4);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Strobe without cycle, and cycle without strobe: never acked.
        wb_stb_i = 1'b1;
        repeat (4) tick();
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b1;
        repeat (3) tick();
        wb_cyc_i = 1'b0;

        // Single-cycle requests at varying gaps, each acked one cycle after it is sampled.
        for (int g = 1; g <= 7; g += 3) begin
            repeat (g) tick();
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            ack_sb.push_back(tcnt + 1);
            tick();
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end

        // Reset during an ack with the strobe still asserted.
        repeat (2) tick();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        ack_sb.push_back(tcnt + 1);
        tick();
        do_reset(1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        run_until(done_t);

`ifdef PERIODIC_REFRESH_EN
        // Strobe sampled on the same edge the pending refresh is taken: refresh first, ack T_RFC later.
        aref_t = done_t + REF_INT + 1;
        push_cmd(aref_t, CMD_REF, 13'h0000);
        ack_sb.push_back(aref_t + T_RFC);
        run_until(aref_t - 1);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        run_until(aref_t + T_RFC);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        repeat (5) tick();
`else
        // Without the refresh scheduler IDLE stays on NOP well past one refresh interval.
        aref_t = done_t + REF_INT + 100;
        run_until(aref_t);
`endif

        check("cmd_sb_empty", cmd_sb.size(), 0);
        check("ack_sb_empty", ack_sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
